// File: rtl/ddr_rd_pkg.sv
// Shared types and default geometry for the DDR frame reader.
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef logic [1:0] buf_idx_t;

    localparam int DEF_BURST_LEN       = 80;
    localparam int DEF_BURSTS_PER_LINE = 16;
    localparam int DEF_LINES_PER_FRAME = 720;

    localparam int WORDS_PER_LINE = DEF_BURSTS_PER_LINE * DEF_BURST_LEN;
    localparam int FRAME_WORDS    = WORDS_PER_LINE * DEF_LINES_PER_FRAME;

    function automatic int words_per_line(input int bursts, input int burst_len);
        return bursts * burst_len;
    endfunction

endpackage

// File: rtl/ddr_rd_beat_tracker.sv
// Tracks bursts in flight, counts returned beats and produces the pixel
// stream with line/frame markers. Beats arriving with nothing in flight
// (e.g. stragglers after a reset) are dropped.
module ddr_rd_beat_tracker
    import ddr_rd_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int PIX_W           = 24,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int BURSTS_PER_LINE = DEF_BURSTS_PER_LINE,
    parameter int OUT_W           = 2,
    parameter int BURST_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic              i_rdv,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_last_line,
    output logic [OUT_W-1:0]  o_outstanding,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_pix_valid,
    output logic              o_pix_eol,
    output logic              o_pix_eof,
    output logic [7:0]        o_count_frame
);
    logic [OUT_W-1:0]   r_outstanding;
    logic [7:0]         r_beat;
    logic [BURST_W-1:0] r_ret_burst;
    logic [PIX_W-1:0]   r_pix_data;
    logic               r_pix_valid, r_pix_eol, r_pix_eof;
    logic [7:0]         r_count_frame;

    logic w_beat_ok, w_last_beat, w_last_burst, w_line_end;

    generate
        if (DATA_W > PIX_W) begin : g_spare
            logic w_unused_rdata;
            assign w_unused_rdata = ^i_rdata[DATA_W-1:PIX_W];
        end
    endgenerate

    assign w_beat_ok    = i_rdv && (r_outstanding != '0);
    assign w_last_beat  = w_beat_ok && (r_beat == 8'(BURST_LEN - 1));
    assign w_last_burst = (r_ret_burst == BURST_W'(BURSTS_PER_LINE - 1));
    assign w_line_end   = w_last_beat && w_last_burst;

    // Bursts in flight: up on accept, down on the final beat, both cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({i_accept, w_last_beat})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Beat within burst and returned-burst within line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat      <= '0;
            r_ret_burst <= '0;
        end else if (w_beat_ok) begin
            if (w_last_beat) begin
                r_beat      <= '0;
                r_ret_burst <= w_last_burst ? '0 : r_ret_burst + 1'b1;
            end else begin
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    // One-cycle pixel pipeline with markers; frame counter moves with eof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_data    <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_eol     <= 1'b0;
            r_pix_eof     <= 1'b0;
            r_count_frame <= '0;
        end else begin
            r_pix_valid <= w_beat_ok;
            r_pix_eol   <= w_line_end;
            r_pix_eof   <= w_line_end && i_last_line;
            if (w_beat_ok)
                r_pix_data <= i_rdata[PIX_W-1:0];
            if (w_line_end && i_last_line)
                r_count_frame <= r_count_frame + 8'd1;
        end
    end

    assign o_outstanding = r_outstanding;
    assign o_pix_data    = r_pix_data;
    assign o_pix_valid   = r_pix_valid;
    assign o_pix_eol     = r_pix_eol;
    assign o_pix_eof     = r_pix_eof;
    assign o_count_frame = r_count_frame;

endmodule

// File: rtl/ddr_frame_reader_mb.sv
// Avalon-MM burst-read master streaming one video line per request from
// the newest complete frame buffer not owned by the writer.
//
// state | meaning
// IDLE  | waiting for line_request (frame start latches buffer + base)
// ISSUE | issuing the line's bursts, throttled by bursts in flight
// DRAIN | all bursts issued, waiting for the last beat to return
module ddr_frame_reader_mb
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_W          = 30,
    parameter int DATA_W          = 32,
    parameter int PIX_W           = 24,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int BURSTS_PER_LINE = DEF_BURSTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int NUM_BUF         = 3,
    parameter int BUF_STRIDE      = 'h100000,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk_100,
    input  logic              reset_b,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              done_write_frame,
    input  logic [1:0]        wr_buf_idx,
    input  logic [1:0]        wr_active_idx,
    input  logic              line_request,
    output logic              frame_buffer_ready,
    output logic              avm_read,
    output logic [ADDR_W-1:0] avm_address,
    output logic [7:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic [1:0]        rd_buf_idx,
    output logic [7:0]        count_read_frame,
    output logic              overrun
);
    localparam int LINE_WORDS = words_per_line(BURSTS_PER_LINE, BURST_LEN);
    localparam int LINE_W  = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int BURST_W = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    rd_state_t          r_state, w_state_nxt;
    buf_idx_t           r_latest_idx, r_rd_buf_idx, w_sel_idx;
    logic               r_frame_buffer_ready, r_overrun;
    logic [LINE_W-1:0]  r_line;
    logic [BURST_W-1:0] r_burst;
    logic [ADDR_W-1:0]  r_line_base, w_buf_base, w_line_off, w_burst_off;
    logic [OUT_W-1:0]   w_outstanding;
    logic               w_avm_read, w_accept, w_start, w_line_done;
    logic               w_last_line, w_last_burst;

    // Repeat the current buffer when the newest one is still the writer's.
    assign w_sel_idx    = (r_latest_idx == wr_active_idx) ? r_rd_buf_idx : r_latest_idx;
    assign w_buf_base   = base_addr + ADDR_W'(w_sel_idx) * ADDR_W'(BUF_STRIDE);
    assign w_line_off   = ADDR_W'(r_line) * ADDR_W'(LINE_WORDS);
    assign w_burst_off  = ADDR_W'(r_burst) * ADDR_W'(BURST_LEN);
    assign w_last_line  = (r_line == LINE_W'(LINES_PER_FRAME - 1));
    assign w_last_burst = (r_burst == BURST_W'(BURSTS_PER_LINE - 1));
    assign w_accept     = w_avm_read && !avm_waitrequest;

    // Next-state and command decode.
    always_comb begin
        w_state_nxt = r_state;
        w_avm_read  = 1'b0;
        w_start     = 1'b0;
        w_line_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (line_request && r_frame_buffer_ready) begin
                    w_start     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_avm_read = (w_outstanding < OUT_W'(MAX_OUTSTANDING));
                if (w_avm_read && !avm_waitrequest && w_last_burst)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_outstanding == '0) begin
                    w_line_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_100 or negedge reset_b) begin
        if (!reset_b)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Buffer selection, line/burst counters and sticky flags.
    always_ff @(posedge clk_100 or negedge reset_b) begin
        if (!reset_b) begin
            r_latest_idx         <= '0;
            r_rd_buf_idx         <= '0;
            r_frame_buffer_ready <= 1'b0;
            r_overrun            <= 1'b0;
            r_line               <= '0;
            r_burst              <= '0;
            r_line_base          <= '0;
        end else begin
            if (done_write_frame && ({30'd0, wr_buf_idx} < 32'(NUM_BUF))) begin
                r_latest_idx         <= wr_buf_idx;
                r_frame_buffer_ready <= 1'b1;
            end
            if (line_request && (r_state != IDLE))
                r_overrun <= 1'b1;
            if (w_start && (r_line == '0)) begin
                r_rd_buf_idx <= w_sel_idx;
                r_line_base  <= w_buf_base;
            end
            if (w_accept)
                r_burst <= w_last_burst ? '0 : r_burst + 1'b1;
            if (w_line_done)
                r_line <= w_last_line ? '0 : r_line + 1'b1;
        end
    end

    ddr_rd_beat_tracker #(
        .DATA_W          (DATA_W),
        .PIX_W           (PIX_W),
        .BURST_LEN       (BURST_LEN),
        .BURSTS_PER_LINE (BURSTS_PER_LINE),
        .OUT_W           (OUT_W),
        .BURST_W         (BURST_W)
    ) u_beat_tracker (
        .clk           (clk_100),
        .rst_n         (reset_b),
        .i_accept      (w_accept),
        .i_rdv         (avm_readdatavalid),
        .i_rdata       (avm_readdata),
        .i_last_line   (w_last_line),
        .o_outstanding (w_outstanding),
        .o_pix_data    (pix_data),
        .o_pix_valid   (pix_valid),
        .o_pix_eol     (pix_eol),
        .o_pix_eof     (pix_eof),
        .o_count_frame (count_read_frame)
    );

    assign avm_read           = w_avm_read;
    assign avm_address        = r_line_base + w_line_off + w_burst_off;
    assign avm_burstcount     = 8'(BURST_LEN);
    assign frame_buffer_ready = r_frame_buffer_ready;
    assign rd_buf_idx         = r_rd_buf_idx;
    assign overrun            = r_overrun;

endmodule
